// File: rtl/restoring_div.sv
// restoring_div -- multi-cycle unsigned restoring divider.
//
// One quotient bit is produced per RUN cycle. The dividend register is also
// the quotient accumulator: the dividend MSB shifts out into the partial
// remainder while the new quotient bit shifts in at the LSB, so after W
// cycles that register holds the quotient.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request a division (accepted only in IDLE)
//   dividend   unsigned numerator, captured on accept
//   divisor    unsigned denominator, captured on accept
//   busy       high while in RUN or FIN
//   done       one-cycle pulse once quotient/remainder/dbz are updated
//   quotient   result quotient (all ones on divide-by-zero)
//   remainder  result remainder (dividend on divide-by-zero)
//   dbz        divide-by-zero flag for the last result
module restoring_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dbz
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Working state for the operation in flight.
  typedef struct packed {
    logic [W-1:0] dq;    // dividend shifting out / quotient shifting in
    logic [W-1:0] prem;  // partial remainder
    logic [W-1:0] dsr;   // captured divisor
    logic         dz;    // result will be a divide-by-zero
  } work_t;

  state_t        state;
  work_t         wk;
  logic [CW-1:0] cnt;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and trial-subtract with one extra bit so the borrow shows up
  // as the MSB of the difference.
  logic [W:0] shifted;
  logic [W:0] diff;
  logic       take;

  always_comb begin
    shifted = {wk.prem, wk.dq[W-1]};
    diff    = shifted - {1'b0, wk.dsr};
    take    = ~diff[W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wk        <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              // Skip the iterations; the result is fixed by convention.
              wk.dq   <= '1;
              wk.prem <= dividend;
              wk.dsr  <= divisor;
              wk.dz   <= 1'b1;
              state   <= FIN;
            end else begin
              wk.dq   <= dividend;
              wk.prem <= '0;
              wk.dsr  <= divisor;
              wk.dz   <= 1'b0;
              cnt     <= CW'(W);
              state   <= RUN;
            end
          end
        end
        RUN: begin
          // A borrow means the trial subtraction failed: keep the shifted
          // value (restore) and record a 0 quotient bit.
          wk.prem <= take ? diff[W-1:0] : shifted[W-1:0];
          wk.dq   <= {wk.dq[W-2:0], take};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIN;
        end
        FIN: begin
          quotient  <= wk.dq;
          remainder <= wk.prem;
          dbz       <= wk.dz;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div.sv
// tb_restoring_div -- directed + randomized bench for restoring_div (W=8).
// Expected results come from the / and % operators and are queued at
// launch; each done pulse pops one entry and compares results and latency.
// Latency is counted with the cycle following the accepting edge as cycle 1.
module tb_restoring_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  restoring_div #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
    int           acc;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int acc, input string tag);
    exp_t e;
    e.acc = acc;
    e.tag = tag;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1; e.lat = 2;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0; e.lat = W + 2;
    end
    return e;
  endfunction

  // Drive a request so it is seen by the next rising edge; return just
  // after that edge, optionally leaving start asserted.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input bit push, input bit hold);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    if (push) sb.push_back(model(a, b, cyc + 1, tag));
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for done, then score it against the oldest expectation.
  task automatic check_done();
    bit   seen = 0;
    exp_t e;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      chk({e.tag, "_q"}, 32'(quotient), 32'(e.q));
      chk({e.tag, "_r"}, 32'(remainder), 32'(e.r));
      chk({e.tag, "_dbz"}, 32'(dbz), 32'(e.z));
      chk({e.tag, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int pulses;
    logic [W-1:0] a, b;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Basic division and single-cycle done pulse.
    launch(8'd13, 8'd3, "d13_3", 1, 0);
    chk("busy_in_run", 32'(busy), 32'd1);
    check_done();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    launch(8'd5, 8'd9, "d5_9", 1, 0);     check_done();
    launch(8'd255, 8'd1, "d255_1", 1, 0); check_done();

    // Divide by zero, then a normal division must clear dbz.
    launch(8'd200, 8'd0, "d200_0", 1, 0); check_done();
    launch(8'd200, 8'd7, "d200_7", 1, 0); check_done();

    // Start while busy must be ignored, operands included.
    launch(8'd100, 8'd10, "d100_10", 1, 0);
    @(negedge clk); @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk); @(negedge clk);
    start = 1'b0;
    check_done();
    pulses = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("no_second_done", 32'(pulses), 32'd0);

    // Reset in RUN cycle 3: everything clears at once, no done.
    launch(8'd77, 8'd3, "d77_3", 0, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(dbz), 32'd0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    rst = 1'b0;
    // launch drives at the next negedge, so the first edge after release
    // accepts it.
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    sb.push_back(model(8'd9, 8'd2, cyc + 1, "d9_2"));
    @(posedge clk); #1; start = 1'b0;
    chk("accept_after_rst", 32'(busy), 32'd1);
    check_done();

    // Back-to-back with start held high across done; the second operands
    // are presented while the first op runs and must not disturb it.
    launch(8'd23, 8'd4, "b2b_a", 1, 1);
    dividend = 8'd99; divisor = 8'd7;
    check_done();
    sb.push_back(model(8'd99, 8'd7, cyc + 1, "b2b_b"));
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept", 32'(busy), 32'd1);
    dividend = 8'd1; divisor = 8'd1;
    repeat (4) @(negedge clk);
    chk("hold_q", 32'(quotient), 32'd5);
    chk("hold_r", 32'(remainder), 32'd3);
    check_done();

    // Randomized operands, with regular divide-by-zero cases.
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 5 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      launch(a, b, "rnd", 1, 0);
      check_done();
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/restoring_div.md
RESTORING_DIV -- requirements
Module: restoring_div

Interface
REQ-001 SHALL have parameter: W, 8, operand width in bits (W >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  request a division; sampled on clk.
REQ-005 SHALL have port: dividend  input  W  unsigned numerator; captured when start is accepted.
REQ-006 SHALL have port: divisor  input  W  unsigned denominator; captured when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while a division is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when the result is ready.
REQ-009 SHALL have port: quotient  output  W  unsigned quotient.
REQ-010 SHALL have port: remainder  output  W  unsigned remainder.
REQ-011 SHALL have port: dbz  output  1  divide-by-zero flag for the last result.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIN.
REQ-013 SHALL, in IDLE with start=1 and divisor!=0, capture the operands, clear the partial remainder, load the iteration counter with W, and enter RUN.
REQ-014 SHALL, in IDLE with start=1 and divisor=0, enter FIN directly with quotient = all ones, remainder = dividend, dbz=1.
REQ-015 SHALL, in RUN, each cycle:
- shift {partial remainder, dividend MSB} left one bit;
- trial-subtract the divisor with W+1-bit width;
- on a non-negative result, keep the difference and shift 1 into the quotient LSB;
- otherwise restore and shift 0 into the quotient LSB;
- decrement the counter.
REQ-016 SHALL leave RUN for FIN on the cycle the counter reaches 0, i.e. after exactly W RUN cycles.
REQ-017 SHALL, in FIN, assert done for exactly one cycle, update quotient/remainder/dbz, and return to IDLE on the next edge.
REQ-018 SHALL give a latency of W+2 cycles from the accepting start edge to the done pulse for divisor!=0, and 2 cycles for divisor=0.
REQ-019 SHALL hold busy=1 in RUN and FIN and busy=0 in IDLE.
REQ-020 SHALL ignore start while busy=1, with no effect on the running operation or its operands.
REQ-021 SHALL accept a start asserted in IDLE in the cycle immediately after done, giving back-to-back operation.
REQ-022 SHALL keep quotient, remainder and dbz stable from one done pulse until the next done pulse, unaffected by input changes.
REQ-023 SHALL clear dbz on any completed division with divisor!=0.
REQ-024 SHALL give results that satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for all divisor!=0.

Reset
REQ-025 SHALL, on rst=1 and independent of clk, force state IDLE, busy=0, done=0, quotient=0, remainder=0, dbz=0, and clear the counter and partial remainder.
REQ-026 SHALL abort an in-progress division when reset is asserted mid-RUN, with no done pulse for that operation.
REQ-027 SHALL accept a new start on the first rising edge after rst is deasserted.

Verification
REQ-028 SHALL cover basic division: W=8, 13/3 -> done after 10 cycles, quotient=4, remainder=1, dbz=0.
REQ-029 SHALL cover a small dividend: 5/9 -> quotient=0, remainder=5; 255/1 -> quotient=255, remainder=0.
REQ-030 SHALL cover divide by zero: 200/0 -> done after 2 cycles, quotient=8'hFF, remainder=200, dbz=1; then 200/7 -> quotient=28, remainder=4, dbz=0.
REQ-031 SHALL cover start while busy: 100/10 started, then 50/5 asserted during RUN -> single done with quotient=10, remainder=0, and no second done.
REQ-032 SHALL cover reset mid-operation: rst pulsed in RUN cycle 3 -> busy=0 and all outputs 0 immediately with no done; then 9/2 -> quotient=4, remainder=1.
REQ-033 SHALL cover back-to-back operation: start held high across done -> second operation accepted the cycle after done, with each result matching REQ-024.
